// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: read-owner encoding and
// the legal range of the DMA starvation limit.
package mem_arb_pkg;

    localparam int unsigned OWNER_W      = 2;
    localparam int unsigned WAIT_CNT_W   = 4;
    localparam int unsigned MAX_WAIT_MIN = 1;
    localparam int unsigned MAX_WAIT_MAX = 15;

    typedef enum logic [OWNER_W-1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // Owner of a granted access, or OWN_NONE when it is not a read.
    function automatic owner_e read_owner(input logic cpu_win, input logic cpu_we,
                                          input logic dma_win, input logic dma_we);
        owner_e owner;
        owner = OWN_NONE;
        if (cpu_win && !cpu_we) begin
            owner = OWN_CPU;
        end else if (dma_win && !dma_we) begin
            owner = OWN_DMA;
        end
        return owner;
    endfunction

endpackage

// File: rtl/arb_prio_guard.sv
// Per-cycle winner select between CPU and DMA: CPU has priority, but a DMA
// request denied MAX_WAIT consecutive cycles wins the next contested cycle.
module arb_prio_guard
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  dma_req,
    output logic                  cpu_win,
    output logic                  dma_win,
    output logic [WAIT_CNT_W-1:0] wait_cnt
);

    if (MAX_WAIT < MAX_WAIT_MIN || MAX_WAIT > MAX_WAIT_MAX) begin : g_bad_max_wait
        $error("arb_prio_guard: MAX_WAIT out of range 1..15");
    end

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic                  at_limit;
    logic [WAIT_CNT_W-1:0] wait_cnt_next;

    // Winner select; both grants are held low while reset is asserted.
    always_comb begin
        at_limit = (wait_cnt == WAIT_LIMIT);
        dma_win  = 1'b0;
        cpu_win  = 1'b0;
        if (!rst) begin
            dma_win = dma_req && (!cpu_req || at_limit);
            cpu_win = cpu_req && !dma_win;
        end
    end

    // Starvation counter: counts only cycles where DMA asked and CPU took the slot.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (!dma_req || dma_win) begin
            wait_cnt_next = '0;
        end else if (cpu_win && !at_limit) begin
            wait_cnt_next = wait_cnt + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU load/store port and the
// DMA/debug port, and steers read data back to whichever port issued the read.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic                  cpu_win;
    logic                  dma_win;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    owner_e                rd_owner;
    owner_e                rd_owner_next;
    logic [DATA_W-1:0]     cpu_rdata_q;
    logic [DATA_W-1:0]     dma_rdata_q;

    arb_prio_guard #(
        .MAX_WAIT (MAX_WAIT)
    ) u_guard (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .cpu_win  (cpu_win),
        .dma_win  (dma_win),
        .wait_cnt (wait_cnt)
    );

    assign cpu_gnt = cpu_win;
    assign dma_gnt = dma_win;

    // Memory-side mux driven from the winner's payload; idle when nobody wins.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_win) begin
            mem_read  = !cpu_we;
            mem_write = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_win) begin
            mem_read  = !dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    always_comb begin
        rd_owner_next = read_owner(cpu_win, cpu_we, dma_win, dma_we);
    end

    // rd_owner marks the cycle in which mem_rdata belongs to a requester;
    // the hold registers keep the last returned word for each port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner    <= OWN_NONE;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            rd_owner <= rd_owner_next;
            if (rd_owner == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (rd_owner == OWN_DMA) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    // Return path: memory data arrives the cycle after the grant, so it is
    // forwarded directly to the owner during that cycle.
    always_comb begin
        cpu_rvalid = (rd_owner == OWN_CPU);
        dma_rvalid = (rd_owner == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;
    end

endmodule
